// File: rtl/lives_manager_pkg.sv
// Shared game parameters: state encoding, lives width and default lives settings
// used by the game logic and the LED lives display.
package lives_manager_pkg;

    localparam int LIVES_W           = 4;
    localparam int DEF_INIT_LIVES    = 3;
    localparam int DEF_MAX_LIVES     = 3;
    localparam int DEF_INVULN_CYCLES = 12_500_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } gameState_t;

    // Add one life unless the ceiling is already reached.
    function automatic logic [LIVES_W-1:0] satIncrement(
        input logic [LIVES_W-1:0] lives,
        input logic [LIVES_W-1:0] ceiling
    );
        return (lives >= ceiling) ? lives : lives + LIVES_W'(1);
    endfunction

endpackage

// File: rtl/invuln_timer.sv
// Post-hit invulnerability countdown: load starts a CYCLES-long window and
// done_o pulses on the last cycle of that window.
module invuln_timer #(
    parameter int CYCLES = 8,
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic done_o
);

    localparam logic [W-1:0] LOAD_VALUE = W'(CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         active_q;
    logic         active_d;

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (load_i) begin
            count_d  = LOAD_VALUE;
            active_d = 1'b1;
        end else if (active_q) begin
            if (count_q == '0) begin
                active_d = 1'b0;
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    // Terminal count of an armed window; active_q drops right after, so one pulse.
    assign done_o = active_q && (count_q == '0);

endmodule

// File: rtl/lives_manager.sv
// Player lives bookkeeping: start/hit/bonus handling, post-hit invulnerability
// and game-over detection, with all outputs registered.
module lives_manager
    import lives_manager_pkg::*;
#(
    parameter int INIT_LIVES    = DEF_INIT_LIVES,
    parameter int MAX_LIVES     = DEF_MAX_LIVES,
    parameter int INVULN_CYCLES = DEF_INVULN_CYCLES
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Start,
    input  logic               i_Hit,
    input  logic               i_Bonus,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Game_Over,
    output logic               o_Invuln,
    output logic               o_Respawn
);

    localparam logic [LIVES_W-1:0] INIT_VALUE = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] MAX_VALUE  = LIVES_W'(MAX_LIVES);

    gameState_t         state_q;
    logic [LIVES_W-1:0] lives_q;
    logic               gameOver_q;
    logic               invuln_q;
    logic               respawn_q;
    logic               timerLoad;
    logic               timerDone;

    // Only a non-fatal hit while vulnerable arms the window; hits in INVULN never reload it.
    assign timerLoad = (state_q == PLAYING) && i_Hit && (lives_q > LIVES_W'(1));

    invuln_timer #(
        .CYCLES (INVULN_CYCLES)
    ) u_invulnTimer (
        .clk_i   (i_Clk),
        .reset_i (i_Reset),
        .load_i  (timerLoad),
        .done_o  (timerDone)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            lives_q    <= INIT_VALUE;
            gameOver_q <= 1'b0;
            invuln_q   <= 1'b0;
            respawn_q  <= 1'b0;
        end else begin
            respawn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_Start) begin
                        state_q <= PLAYING;
                        lives_q <= INIT_VALUE;
                    end
                end
                PLAYING: begin
                    // A hit outranks a same-cycle bonus, which is simply dropped.
                    if (i_Hit) begin
                        if (lives_q > LIVES_W'(1)) begin
                            lives_q   <= lives_q - LIVES_W'(1);
                            respawn_q <= 1'b1;
                            invuln_q  <= 1'b1;
                            state_q   <= INVULN;
                        end else begin
                            lives_q    <= '0;
                            gameOver_q <= 1'b1;
                            state_q    <= GAME_OVER;
                        end
                    end else if (i_Bonus) begin
                        lives_q <= satIncrement(lives_q, MAX_VALUE);
                    end
                end
                INVULN: begin
                    if (timerDone) begin
                        state_q  <= PLAYING;
                        invuln_q <= 1'b0;
                    end
                    if (i_Bonus) begin
                        lives_q <= satIncrement(lives_q, MAX_VALUE);
                    end
                end
                GAME_OVER: begin
                    if (i_Start) begin
                        state_q    <= PLAYING;
                        lives_q    <= INIT_VALUE;
                        gameOver_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_Lives     = lives_q;
    assign o_Game_Over = gameOver_q;
    assign o_Invuln    = invuln_q;
    assign o_Respawn   = respawn_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager with an 8-cycle invulnerability window;
// expected values are hand-derived and checked by immediate assertions.
module tb_lives_manager;

    logic       clk;
    logic       reset;
    logic       start;
    logic       hit;
    logic       bonus;
    logic [3:0] lives;
    logic       gameOver;
    logic       invuln;
    logic       respawn;

    int assertCount = 0;
    int failCount   = 0;

    lives_manager #(
        .INIT_LIVES    (3),
        .MAX_LIVES     (3),
        .INVULN_CYCLES (8)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (reset),
        .i_Start     (start),
        .i_Hit       (hit),
        .i_Bonus     (bonus),
        .o_Lives     (lives),
        .o_Game_Over (gameOver),
        .o_Invuln    (invuln),
        .o_Respawn   (respawn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of pulses at the falling edge, then settle just past the rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic h, input logic b);
        @(negedge clk);
        reset = r;
        start = s;
        hit   = h;
        bonus = b;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        hit   = 1'b0;
        bonus = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expLives,
                               input logic expGo, input logic expInv, input logic expResp);
        logic [6:0] observed;
        logic [6:0] expected;
        observed = {lives, gameOver, invuln, respawn};
        expected = {expLives, expGo, expInv, expResp};
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: got lives=%0d go=%b inv=%b resp=%b, expected lives=%0d go=%b inv=%b resp=%b",
                   tag, lives, gameOver, invuln, respawn, expLives, expGo, expInv, expResp);
        end
    endtask

    // After a hit (window cycle 1 already checked), cycles 2..8 stay invulnerable, then drop.
    task automatic waitWindow(input string tag, input logic [3:0] expLives);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput(tag, expLives, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_end"}, expLives, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        hit   = 1'b0;
        bonus = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_hit_ignored", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("start", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bonus_saturate", 4'd3, 1'b0, 1'b0, 1'b0);

        // First hit, then a second hit on window cycle 3 that must neither decrement nor reload.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hit1_cycle1", 4'd2, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hit1_cycle2", 4'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("invuln_hit_ignored", 4'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 4; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("window_no_reload", 4'd2, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("window_drop", 4'd2, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_in_playing", 4'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bonus_playing", 4'd3, 1'b0, 1'b0, 1'b0);

        // Hit from 3, then a bonus during the window restores 3 without ending it early.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hit2", 4'd2, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bonus_invuln", 4'd3, 1'b0, 1'b1, 1'b0);
        for (int i = 3; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("window_after_bonus", 4'd3, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("window_after_bonus_end", 4'd3, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hit3", 4'd2, 1'b0, 1'b1, 1'b1);
        waitWindow("hit3_window", 4'd2);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("hit_bonus_same_cycle", 4'd1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_in_invuln", 4'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_mid_invuln", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_after_reset", 4'd3, 1'b0, 1'b0, 1'b0);

        // Three spaced hits down to game over, then restart.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("restart", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("go_hit1", 4'd2, 1'b0, 1'b1, 1'b1);
        waitWindow("go_hit1_window", 4'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("go_hit2", 4'd1, 1'b0, 1'b1, 1'b1);
        waitWindow("go_hit2_window", 4'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fatal_hit", 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("gameover_bonus", 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("gameover_hit", 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("gameover_start", 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("playing_after_restart", 4'd2, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/lives_manager.md
LIVES_MANAGER -- requirements
Module: lives_manager

Interface
REQ-001 Parameter INIT_LIVES, default 3, lives loaded on start and on reset.
REQ-002 Parameter MAX_LIVES, default 3, saturation ceiling for bonus lives.
REQ-003 Parameter INVULN_CYCLES, default 12_500_000, length of post-hit invulnerability window in clock cycles (0.5 s at 25 MHz).
REQ-004 i_Clk  input  1  system clock; all logic on rising edge.
REQ-005 i_Reset  input  1  synchronous, active-high reset.
REQ-006 i_Start  input  1  one-cycle pulse; begins a game.
REQ-007 i_Hit  input  1  one-cycle pulse; player collision.
REQ-008 i_Bonus  input  1  one-cycle pulse; extra life earned.
REQ-009 o_Lives  output  4  current remaining lives, unsigned, drives LED display block.
REQ-010 o_Game_Over  output  1  high while in GAME_OVER.
REQ-011 o_Invuln  output  1  high while in INVULN (hit immunity; display may blink player).
REQ-012 o_Respawn  output  1  one-cycle pulse on each non-fatal hit; commands player reposition.

Function
REQ-013 State machine SHALL have states IDLE, PLAYING, INVULN, GAME_OVER.
REQ-014 All outputs SHALL be registered; response to any input pulse SHALL appear on outputs exactly one cycle after the sampling edge.
REQ-015 IDLE: i_Start -> PLAYING, o_Lives = INIT_LIVES; i_Hit, i_Bonus ignored.
REQ-016 PLAYING, i_Hit with o_Lives > 1 -> o_Lives decremented by 1, o_Respawn pulsed for one cycle, state INVULN, timer loaded with INVULN_CYCLES-1.
REQ-017 PLAYING, i_Hit with o_Lives == 1 -> o_Lives = 0, state GAME_OVER, o_Game_Over = 1, no o_Respawn pulse.
REQ-018 INVULN: timer decrements each cycle; on the cycle it reads 0 state SHALL return to PLAYING, so o_Invuln is high for exactly INVULN_CYCLES cycles.
REQ-019 INVULN: i_Hit SHALL be ignored (no decrement, no timer reload).
REQ-020 PLAYING or INVULN, i_Bonus SHALL increment o_Lives, saturating at MAX_LIVES; bonus SHALL not alter state or timer.
REQ-021 Simultaneous i_Hit and i_Bonus in PLAYING: hit SHALL take priority, bonus dropped.
REQ-022 GAME_OVER: i_Hit, i_Bonus ignored; i_Start -> PLAYING with o_Lives = INIT_LIVES, o_Game_Over cleared.
REQ-023 i_Start in PLAYING or INVULN SHALL be ignored.
REQ-024 o_Lives SHALL never exceed MAX_LIVES nor wrap below 0.
REQ-025 Timer width SHALL be $clog2(INVULN_CYCLES) bits minimum; INVULN_CYCLES >= 1.

Reset
REQ-026 i_Reset SHALL override all inputs at any state, including mid-INVULN.
REQ-027 Reset values: state IDLE, o_Lives = INIT_LIVES, o_Game_Over = 0, o_Invuln = 0, o_Respawn = 0, timer = 0.

Structure
REQ-028 State encodings, MAX_LIVES, INIT_LIVES and lives width SHALL live in the shared game parameters package used by the LED display and game logic.
REQ-029 Invulnerability countdown SHALL be a sub-module invuln_timer (load, count-down, done pulse).

Verification (bench uses INVULN_CYCLES = 8)
REQ-030 Reset, then i_Start -> next cycle o_Lives = 3, o_Game_Over = 0, o_Invuln = 0.
REQ-031 In PLAYING, i_Hit -> next cycle o_Lives = 2, o_Respawn = 1 for one cycle, o_Invuln = 1 for exactly 8 cycles, then 0.
REQ-032 i_Hit at 3rd cycle of INVULN -> o_Lives remains 2, o_Invuln still drops after cycle 8 of window.
REQ-033 Three spaced hits from 3 lives -> o_Lives 2, 1, 0; third hit sets o_Game_Over = 1 with no o_Respawn; subsequent i_Bonus leaves o_Lives = 0; i_Start restores o_Lives = 3.
REQ-034 o_Lives = 3, i_Bonus -> stays 3; o_Lives = 2, i_Hit and i_Bonus same cycle -> o_Lives = 1, INVULN entered.
REQ-035 i_Reset asserted mid-INVULN with o_Lives = 1 -> next cycle state IDLE, o_Lives = 3, o_Invuln = 0, o_Respawn = 0.
